// File: rtl/adc_spi_pkg.sv
//------------------------------------------------------------------------------
// adc_spi_pkg
// Shared types, frame constants and helpers for the SPI ADC sampler.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package adc_spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        DONE     = 3'd4
    } adc_state_t;

    localparam int FRAME_BITS   = 17;
    localparam int NULL_BIT_IDX = 4;

    // Offset-binary 12-bit reading to left-justified two's complement.
    function automatic logic signed [15:0] adc12_to_pcm16(input logic [11:0] d);
        return $signed({~d[11], d[10:0], 4'b0000});
    endfunction

    // Command stream: start, single-ended, channel select, MSB-first, then zeros.
    function automatic logic cmd_bit(input logic [4:0] idx, input logic chan);
        case (idx)
            5'd0, 5'd1, 5'd3: return 1'b1;
            5'd2:             return chan;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_frame_shifter.sv
//------------------------------------------------------------------------------
// spi_frame_shifter
// Generates adc_clk, emits the command bits and captures one 17-bit frame.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_frame_shifter
    import adc_spi_pkg::*;
#(
    parameter int SCLK_HALF = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic        chan_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        done_o,
    output logic [11:0] data_o
);

    localparam int             HW        = $clog2(SCLK_HALF);
    localparam logic [HW-1:0]  HALF_LAST = HW'(SCLK_HALF - 1);
    localparam logic [4:0]     IDX_LAST  = 5'(FRAME_BITS - 1);
    localparam logic [4:0]     IDX_NULL  = 5'(NULL_BIT_IDX);

    logic          miso_meta_q, miso_sync_q;
    logic          active_q, active_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          chan_q, chan_d;
    logic [HW-1:0] half_q, half_d;
    logic [4:0]    idx_q, idx_d;
    logic [11:0]   shift_q, shift_d;
    logic          w_half_end;

    assign w_half_end = (half_q == HALF_LAST);

    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        chan_d   = chan_q;
        half_d   = half_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        if (start_i) begin
            active_d = 1'b1;
            sclk_d   = 1'b0;
            half_d   = '0;
            idx_d    = 5'd0;
            chan_d   = chan_i;
            mosi_d   = cmd_bit(5'd0, chan_i);
            shift_d  = '0;
        end else if (active_q) begin
            if (w_half_end) begin
                half_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    // End of high phase: sample, then open the next low phase.
                    sclk_d = 1'b0;
                    if (idx_q > IDX_NULL) begin
                        shift_d = {shift_q[10:0], miso_sync_q};
                    end
                    if (idx_q == IDX_LAST) begin
                        active_d = 1'b0;
                        mosi_d   = 1'b0;
                    end else begin
                        idx_d  = idx_q + 5'd1;
                        mosi_d = cmd_bit(idx_q + 5'd1, chan_q);
                    end
                end
            end else begin
                half_d = half_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
            active_q    <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            chan_q      <= 1'b0;
            half_q      <= '0;
            idx_q       <= 5'd0;
            shift_q     <= '0;
        end else begin
            miso_meta_q <= miso_i;
            miso_sync_q <= miso_meta_q;
            active_q    <= active_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            chan_q      <= chan_d;
            half_q      <= half_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
        end
    end

    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    assign done_o = active_q && sclk_q && w_half_end && (idx_q == IDX_LAST);
    assign data_o = shift_q;

endmodule

`default_nettype wire

// File: rtl/adc_spi_sampler.sv
//------------------------------------------------------------------------------
// adc_spi_sampler
// Periodically reads both channels of an SPI ADC and outputs a PCM sample pair.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module adc_spi_sampler
    import adc_spi_pkg::*;
#(
    parameter int CLK_FREQ     = 27_000_000,
    parameter int SAMPLE_RATE  = 48_000,
    parameter int SCLK_HALF    = 6,
    parameter bit CHECK_TIMING = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        adc_clk,
    output logic        adc_cs,
    output logic        adc_mosi,
    input  logic        adc_miso,
    output logic [15:0] sample_l,
    output logic [15:0] sample_r,
    output logic        sample_valid,
    output logic        overrun,
    input  logic        overrun_clr
);

    localparam int             TICK_PERIOD = CLK_FREQ / SAMPLE_RATE;
    localparam int             TW          = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [TW-1:0]  TICK_LAST   = TW'(TICK_PERIOD - 1);
    localparam int             HW          = $clog2(SCLK_HALF);
    localparam logic [HW-1:0]  PHASE_LAST  = HW'(SCLK_HALF - 1);

    generate
        if (SCLK_HALF < 4) begin : g_sclk_check
            $fatal(1, "adc_spi_sampler: SCLK_HALF must be at least 4");
        end
        if (CHECK_TIMING) begin : g_rate_check
            if (2 * (2 * FRAME_BITS * SCLK_HALF + 2 * SCLK_HALF) + 4 >= TICK_PERIOD) begin : g_rate_fail
                $fatal(1, "adc_spi_sampler: sample pair does not fit in one sample period");
            end
        end
    endgenerate

    adc_state_t    state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [HW-1:0] phase_q, phase_d;
    logic          chan_q, chan_d;
    logic [11:0]   left_word_q, left_word_d;
    logic [15:0]   sample_l_q, sample_l_d;
    logic [15:0]   sample_r_q, sample_r_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          cs_q, cs_d;

    logic          w_tick;
    logic          w_start;
    logic          w_sclk;
    logic          w_frame_mosi;
    logic          w_frame_done;
    logic [11:0]   w_frame_data;

    spi_frame_shifter #(
        .SCLK_HALF (SCLK_HALF)
    ) u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (w_start),
        .chan_i  (chan_q),
        .miso_i  (adc_miso),
        .sclk_o  (w_sclk),
        .mosi_o  (w_frame_mosi),
        .done_o  (w_frame_done),
        .data_o  (w_frame_data)
    );

    assign w_tick = enable && (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (!enable) begin
            tick_cnt_d = '0;
        end else if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end

        // A drop this cycle outranks a simultaneous clear.
        overrun_d = overrun_q;
        if (w_tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        chan_d      = chan_q;
        left_word_d = left_word_q;
        sample_l_d  = sample_l_q;
        sample_r_d  = sample_r_q;
        valid_d     = 1'b0;
        w_start     = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_tick) begin
                    state_d = CS_SETUP;
                    chan_d  = 1'b0;
                    phase_d = '0;
                end
            end
            CS_SETUP: begin
                if (phase_q == PHASE_LAST) begin
                    state_d = SHIFT;
                    w_start = 1'b1;
                end else begin
                    phase_d = phase_q + HW'(1);
                end
            end
            SHIFT: begin
                if (w_frame_done) begin
                    state_d = CS_HOLD;
                    phase_d = '0;
                end
            end
            CS_HOLD: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    if (!chan_q) begin
                        left_word_d = w_frame_data;
                        chan_d      = 1'b1;
                        state_d     = CS_SETUP;
                    end else begin
                        // Both outputs change together only once the pair is whole.
                        sample_l_d = adc12_to_pcm16(left_word_q);
                        sample_r_d = adc12_to_pcm16(w_frame_data);
                        valid_d    = 1'b1;
                        state_d    = DONE;
                    end
                end else begin
                    phase_d = phase_q + HW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cs_d = !((state_d == CS_SETUP) || (state_d == SHIFT));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            phase_q     <= '0;
            chan_q      <= 1'b0;
            left_word_q <= '0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            cs_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            phase_q     <= phase_d;
            chan_q      <= chan_d;
            left_word_q <= left_word_d;
            sample_l_q  <= sample_l_d;
            sample_r_q  <= sample_r_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            cs_q        <= cs_d;
        end
    end

    assign adc_clk      = w_sclk;
    assign adc_cs       = cs_q;
    assign adc_mosi     = (state_q == CS_SETUP) | w_frame_mosi;
    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_sampler.sv
//------------------------------------------------------------------------------
// tb_adc_spi_sampler
// Directed bench for adc_spi_sampler with a behavioural two-channel ADC.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_adc_spi_sampler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        adc_clk;
    logic        adc_cs;
    logic        adc_mosi;
    logic        adc_miso = 1'b0;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        overrun;
    logic        overrun_clr;

    int checks = 0;
    int errors = 0;

    logic [11:0] ch0_val = 12'h000;
    logic [11:0] ch1_val = 12'h000;

    // ADC model bookkeeping, all owned by the clk-sampled monitor.
    logic       prev_cs     = 1'b1;
    logic       prev_sclk   = 1'b0;
    logic [4:0] frame_no    = 5'd0;
    int         rise_cnt [32];
    logic [3:0] cmd_bits [32];
    int         gap_at   [32];
    int         cs_high_run = 0;
    int         cyc         = 0;
    int         last_rise   = 0;
    int         sclk_period = 0;
    int         valid_cnt   = 0;

    adc_spi_sampler #(
        .CLK_FREQ     (14_400_000),
        .SAMPLE_RATE  (48_000),
        .SCLK_HALF    (6),
        .CHECK_TIMING (1'b0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .adc_clk      (adc_clk),
        .adc_cs       (adc_cs),
        .adc_mosi     (adc_mosi),
        .adc_miso     (adc_miso),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        prev_cs     <= adc_cs;
        prev_sclk   <= adc_clk;
        cs_high_run <= adc_cs ? cs_high_run + 1 : 0;
        valid_cnt   <= valid_cnt + (sample_valid ? 1 : 0);
        if (prev_cs && !adc_cs) begin
            rise_cnt[frame_no] <= 0;
            gap_at[frame_no]   <= cs_high_run;
            frame_no           <= frame_no + 5'd1;
        end
        if (!prev_sclk && adc_clk && !adc_cs) begin
            if (rise_cnt[frame_no - 5'd1] < 4)
                cmd_bits[frame_no - 5'd1] <= {cmd_bits[frame_no - 5'd1][2:0], adc_mosi};
            if (rise_cnt[frame_no - 5'd1] > 0)
                sclk_period <= cyc - last_rise;
            last_rise <= cyc;
            rise_cnt[frame_no - 5'd1] <= rise_cnt[frame_no - 5'd1] + 1;
        end
    end

    // The ADC shifts its next bit out on each falling adc_clk edge.
    always @(negedge adc_clk) begin : miso_model
        int          n;
        logic [11:0] w;
        n = rise_cnt[frame_no - 5'd1];
        w = cmd_bits[frame_no - 5'd1][1] ? ch1_val : ch0_val;
        if (n >= 5 && n <= 16) begin
            w = w >> (16 - n);
            adc_miso <= w[0];
        end else begin
            adc_miso <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         vc;
        logic [4:0] base;
        logic [4:0] exp5;

        reset_n     = 1'b0;
        enable      = 1'b0;
        overrun_clr = 1'b0;
        ch0_val     = 12'h800;
        ch1_val     = 12'hFFF;
        repeat (5) @(posedge clk);
        #1;
        check("rst_cs",      {31'd0, adc_cs},       32'd1);
        check("rst_sclk",    {31'd0, adc_clk},      32'd0);
        check("rst_mosi",    {31'd0, adc_mosi},     32'd0);
        check("rst_l",       {16'd0, sample_l},     32'h0);
        check("rst_r",       {16'd0, sample_r},     32'h0);
        check("rst_valid",   {31'd0, sample_valid}, 32'd0);
        check("rst_overrun", {31'd0, overrun},      32'd0);
        reset_n = 1'b1;

        // Pair 1: mid-scale / full-scale, enable dropped 100 cycles after the tick.
        step();
        base   = frame_no;
        vc     = valid_cnt;
        enable = 1'b1;
        n      = 0;
        while (n < 800 && !sample_valid) begin
            step();
            n++;
            if (n == 400) enable = 1'b0;
        end
        check("t1_latency", n, 32'd732);
        check("t1_l", {16'd0, sample_l}, 32'h0000);
        check("t1_r", {16'd0, sample_r}, 32'h7FF0);
        step();
        check("t1_valid_pulse", {31'd0, sample_valid}, 32'd0);
        check("t1_rises_f0", rise_cnt[base], 32'd17);
        check("t1_rises_f1", rise_cnt[base + 5'd1], 32'd17);
        check("t1_cmd_f0", {28'd0, cmd_bits[base]}, 32'hD);
        check("t1_cmd_f1", {28'd0, cmd_bits[base + 5'd1]}, 32'hF);
        check("t1_cs_gap_ge6", {31'd0, gap_at[base + 5'd1] >= 6}, 32'd1);
        check("t1_sclk_period", sclk_period, 32'd12);
        repeat (900) step();
        exp5 = base + 5'd2;
        check("t1_no_new_frames", {27'd0, frame_no}, {27'd0, exp5});
        check("t1_valid_count", valid_cnt - vc, 32'd1);
        check("t1_r_hold", {16'd0, sample_r}, 32'h7FF0);
        check("t1_no_overrun", {31'd0, overrun}, 32'd0);

        // Pair 2: zero-scale / small positive-offset value.
        ch0_val = 12'h000;
        ch1_val = 12'h123;
        base    = frame_no;
        enable  = 1'b1;
        n       = 0;
        while (n < 800 && !sample_valid) begin
            step();
            n++;
            if (n == 400) enable = 1'b0;
        end
        check("t2_latency", n, 32'd732);
        check("t2_l", {16'd0, sample_l}, 32'h8000);
        check("t2_r", {16'd0, sample_r}, 32'h9230);
        check("t2_sclk_period", sclk_period, 32'd12);
        check("t2_cmd_f1", {28'd0, cmd_bits[base + 5'd1]}, 32'hF);
        repeat (10) step();

        // Overrun: ticks every 300 cycles against a 433-cycle pair.
        ch0_val = 12'hABC;
        ch1_val = 12'h456;
        enable  = 1'b1;
        n       = 0;
        while (n < 599) begin step(); n++; end
        check("t3_ovr_before_drop", {31'd0, overrun}, 32'd0);
        step(); n++;
        check("t3_ovr_set", {31'd0, overrun}, 32'd1);
        while (n < 640) begin step(); n++; end
        check("t3_ovr_sticky", {31'd0, overrun}, 32'd1);
        while (n < 649) begin step(); n++; end
        overrun_clr = 1'b1;
        step(); n++;
        overrun_clr = 1'b0;
        check("t3_ovr_cleared", {31'd0, overrun}, 32'd0);
        while (n < 800 && !sample_valid) begin step(); n++; end
        check("t3_latency", n, 32'd732);
        check("t3_l", {16'd0, sample_l}, 32'h2BC0);
        check("t3_r", {16'd0, sample_r}, 32'hC560);
        while (n < 1199) begin step(); n++; end
        check("t3_ovr_still_clear", {31'd0, overrun}, 32'd0);
        overrun_clr = 1'b1;
        step(); n++;
        overrun_clr = 1'b0;
        enable      = 1'b0;
        check("t3_ovr_set_wins", {31'd0, overrun}, 32'd1);
        while (n < 1400 && !sample_valid) begin step(); n++; end
        check("t3_second_pair", n, 32'd1332);
        check("t3_l2", {16'd0, sample_l}, 32'h2BC0);
        repeat (5) step();
        check("t3_ovr_final", {31'd0, overrun}, 32'd1);

        // Reset asserted inside the second frame, then a fresh pair.
        ch0_val = 12'h7FF;
        ch1_val = 12'h001;
        base    = frame_no;
        exp5    = base + 5'd2;
        enable  = 1'b1;
        n       = 0;
        while (frame_no !== exp5 && n < 1000) begin step(); n++; end
        check("t4_second_frame_seen", {27'd0, frame_no}, {27'd0, exp5});
        repeat (13) step();
        check("t4_sclk_high_pre", {31'd0, adc_clk}, 32'd1);
        check("t4_cs_low_pre",    {31'd0, adc_cs},  32'd0);
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check("t4_rst_cs",    {31'd0, adc_cs},       32'd1);
        check("t4_rst_sclk",  {31'd0, adc_clk},      32'd0);
        check("t4_rst_mosi",  {31'd0, adc_mosi},     32'd0);
        check("t4_rst_valid", {31'd0, sample_valid}, 32'd0);
        check("t4_rst_l",     {16'd0, sample_l},     32'h0);
        check("t4_rst_r",     {16'd0, sample_r},     32'h0);
        check("t4_rst_ovr",   {31'd0, overrun},      32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        base    = frame_no;
        enable  = 1'b1;
        n       = 0;
        while (n < 800 && !sample_valid) begin step(); n++; end
        check("t4_latency", n, 32'd732);
        check("t4_l", {16'd0, sample_l}, 32'hFFF0);
        check("t4_r", {16'd0, sample_r}, 32'h8010);
        check("t4_rises_f1", rise_cnt[base + 5'd1], 32'd17);
        enable = 1'b0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
